// File: rtl/pic_control_unit_pkg.sv
// Shared definitions for the PIC16 instruction-cycle controller:
// ALU operation codes, Q-phase states, opcode class values and the
// decoded control bundle.
package pic_control_unit_pkg;

  localparam logic [3:0] alu_op_zero   = 4'd0;
  localparam logic [3:0] alu_op_add    = 4'd1;
  localparam logic [3:0] alu_op_sub    = 4'd2;
  localparam logic [3:0] alu_op_and    = 4'd3;
  localparam logic [3:0] alu_op_ior    = 4'd4;
  localparam logic [3:0] alu_op_xor    = 4'd5;
  localparam logic [3:0] alu_op_com    = 4'd6;
  localparam logic [3:0] alu_op_inc    = 4'd7;
  localparam logic [3:0] alu_op_dec    = 4'd8;
  localparam logic [3:0] alu_op_rlf    = 4'd9;
  localparam logic [3:0] alu_op_rrf    = 4'd10;
  localparam logic [3:0] alu_op_swap   = 4'd11;
  localparam logic [3:0] alu_op_passw  = 4'd12;
  localparam logic [3:0] alu_op_passlf = 4'd13;
  localparam logic [3:0] alu_op_bc     = 4'd14;
  localparam logic [3:0] alu_op_bs     = 4'd15;

  typedef enum logic [1:0] {
    Q1 = 2'd0,
    Q2 = 2'd1,
    Q3 = 2'd2,
    Q4 = 2'd3
  } q_phase_e;

  // Instruction class lives in IR[13:12]
  localparam logic [1:0] OPC_BYTE = 2'b00;
  localparam logic [1:0] OPC_BIT  = 2'b01;
  localparam logic [1:0] OPC_JUMP = 2'b10;
  localparam logic [1:0] OPC_LIT  = 2'b11;

  // Low seven bits of the two return-type encodings in the 0x00xx page
  localparam logic [6:0] RETURN_LOW = 7'h08;
  localparam logic [6:0] RETFIE_LOW = 7'h09;

  localparam logic [13:0] NOP_WORD_DEFAULT = 14'h0000;

  typedef struct packed {
    logic [3:0] op;
    logic       d;
    logic       d_wr_en;
    logic       status_wr_en;
    logic       lit_sel;
    logic       pc_load;
    logic       stack_push;
    logic       stack_pop;
    logic       gie_set;
    logic       is_skip_bit;
    logic       is_skip_z;
    logic       is_branch;
  } ctrl_t;

  // ALU operation for the byte-oriented file-register group, keyed by IR[11:8]
  function automatic logic [3:0] byte_alu_op(input logic [3:0] sel);
    logic [3:0] op;
    case (sel)
      4'h2:    op = alu_op_sub;
      4'h3:    op = alu_op_dec;
      4'h4:    op = alu_op_ior;
      4'h5:    op = alu_op_and;
      4'h6:    op = alu_op_xor;
      4'h7:    op = alu_op_add;
      4'h8:    op = alu_op_passlf;
      4'h9:    op = alu_op_com;
      4'hA:    op = alu_op_inc;
      4'hB:    op = alu_op_dec;
      4'hC:    op = alu_op_rrf;
      4'hD:    op = alu_op_rlf;
      4'hE:    op = alu_op_swap;
      4'hF:    op = alu_op_inc;
      default: op = alu_op_zero;
    endcase
    return op;
  endfunction

  // SWAPF, DECFSZ and INCFSZ leave STATUS untouched
  function automatic logic byte_sets_status(input logic [3:0] sel);
    return !((sel == 4'hB) || (sel == 4'hE) || (sel == 4'hF));
  endfunction

endpackage

// File: rtl/pic_control_unit_if.sv
// Bus between the instruction-cycle controller (master) and the
// datapath / program counter / stack (slave).
interface pic_control_unit_if #(
  parameter int PC_WIDTH = 11
);
  logic [13:0]         instr_in;
  logic                alu_bit_test_res;
  logic                alu_out_z;
  logic [1:0]          q_state;
  logic [3:0]          alu_op;
  logic                alu_d;
  logic                alu_d_wr_en;
  logic                alu_status_wr_en;
  logic                alu_lit_sel;
  logic [2:0]          alu_b_in;
  logic [6:0]          rf_addr;
  logic                pc_inc_en;
  logic                pc_load_en;
  logic [PC_WIDTH-1:0] pc_load_val;
  logic                stack_push;
  logic                stack_pop;
  logic                gie_set;

  modport master (
    input  instr_in, alu_bit_test_res, alu_out_z,
    output q_state, alu_op, alu_d, alu_d_wr_en, alu_status_wr_en,
           alu_lit_sel, alu_b_in, rf_addr, pc_inc_en, pc_load_en,
           pc_load_val, stack_push, stack_pop, gie_set
  );

  modport slave (
    output instr_in, alu_bit_test_res, alu_out_z,
    input  q_state, alu_op, alu_d, alu_d_wr_en, alu_status_wr_en,
           alu_lit_sel, alu_b_in, rf_addr, pc_inc_en, pc_load_en,
           pc_load_val, stack_push, stack_pop, gie_set
  );
endinterface

// File: rtl/pic_instr_decoder.sv
// Purely combinational PIC16 opcode decoder: IR -> ALU, PC and stack
// control plus the skip/branch classification used by the sequencer.
module pic_instr_decoder
  import pic_control_unit_pkg::*;
(
  input  logic [13:0] ir,
  output ctrl_t       ctrl
);

  // Map each instruction class onto its control bundle; undefined words act as NOP
  always_comb begin
    ctrl    = '0;
    ctrl.op = alu_op_zero;
    unique case (ir[13:12])
      OPC_BYTE: begin
        case (ir[11:8])
          4'h0: begin
            if (ir[7]) begin
              ctrl.op      = alu_op_passw;
              ctrl.d       = 1'b1;
              ctrl.d_wr_en = 1'b1;
            end else if (ir[6:0] == RETURN_LOW) begin
              ctrl.stack_pop = 1'b1;
              ctrl.is_branch = 1'b1;
            end else if (ir[6:0] == RETFIE_LOW) begin
              ctrl.stack_pop = 1'b1;
              ctrl.gie_set   = 1'b1;
              ctrl.is_branch = 1'b1;
            end
          end
          4'h1: begin
            ctrl.op           = alu_op_zero;
            ctrl.d            = ir[7];
            ctrl.d_wr_en      = 1'b1;
            ctrl.status_wr_en = 1'b1;
          end
          default: begin
            ctrl.op           = byte_alu_op(ir[11:8]);
            ctrl.d            = ir[7];
            ctrl.d_wr_en      = 1'b1;
            ctrl.status_wr_en = byte_sets_status(ir[11:8]);
            ctrl.is_skip_z    = (ir[11:8] == 4'hB) || (ir[11:8] == 4'hF);
          end
        endcase
      end
      OPC_BIT: begin
        case (ir[11:10])
          2'b00: begin
            ctrl.op      = alu_op_bc;
            ctrl.d       = 1'b1;
            ctrl.d_wr_en = 1'b1;
          end
          2'b01: begin
            ctrl.op      = alu_op_bs;
            ctrl.d       = 1'b1;
            ctrl.d_wr_en = 1'b1;
          end
          2'b10: begin
            ctrl.op          = alu_op_bc;
            ctrl.is_skip_bit = 1'b1;
          end
          default: begin
            ctrl.op          = alu_op_bs;
            ctrl.is_skip_bit = 1'b1;
          end
        endcase
      end
      OPC_JUMP: begin
        ctrl.pc_load    = 1'b1;
        ctrl.stack_push = ~ir[11];
        ctrl.is_branch  = 1'b1;
      end
      default: begin
        ctrl.lit_sel = 1'b1;
        ctrl.d_wr_en = 1'b1;
        casez (ir[11:8])
          4'b00??: ctrl.op = alu_op_passlf;
          4'b01??: begin
            ctrl.op        = alu_op_passlf;
            ctrl.stack_pop = 1'b1;
            ctrl.is_branch = 1'b1;
          end
          4'b1000: begin
            ctrl.op           = alu_op_ior;
            ctrl.status_wr_en = 1'b1;
          end
          4'b1001: begin
            ctrl.op           = alu_op_and;
            ctrl.status_wr_en = 1'b1;
          end
          4'b1010: begin
            ctrl.op           = alu_op_xor;
            ctrl.status_wr_en = 1'b1;
          end
          4'b110?: begin
            ctrl.op           = alu_op_sub;
            ctrl.status_wr_en = 1'b1;
          end
          4'b111?: begin
            ctrl.op           = alu_op_add;
            ctrl.status_wr_en = 1'b1;
          end
          default: begin
            ctrl    = '0;
            ctrl.op = alu_op_zero;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/pic_control_unit.sv
// PIC16 instruction-cycle controller: Q1..Q4 phase counter, instruction
// register, pipeline flush after branches and taken skips, and Q4 gating
// of every write enable and PC/stack pulse.
module pic_control_unit
  import pic_control_unit_pkg::*;
#(
  parameter int          PC_WIDTH = 11,
  parameter logic [13:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  pic_control_unit_if.master bus
);

  q_phase_e    q_state_q, q_state_d;
  logic [13:0] ir_q, ir_d;
  logic        flush_q, flush_d;
  ctrl_t       ctrl;
  logic        in_q4;
  logic        active;
  logic        skip_taken;
  logic        branch_taken;
  logic        next_flush;

  pic_instr_decoder u_decoder (
    .ir   (ir_q),
    .ctrl (ctrl)
  );

  // Resolve whether the current instruction redirects the pipeline; a flushed slot never does
  always_comb begin
    in_q4        = (q_state_q == Q4);
    active       = ~flush_q;
    skip_taken   = active & ((ctrl.is_skip_bit & bus.alu_bit_test_res) |
                             (ctrl.is_skip_z   & bus.alu_out_z));
    branch_taken = active & ctrl.is_branch;
    next_flush   = skip_taken | branch_taken;
  end

  // Next phase, and at the end of Q4 the next IR (NOP when the fetched word is discarded)
  always_comb begin
    q_state_d = q_phase_e'(q_state_q + 2'd1);
    ir_d      = ir_q;
    flush_d   = flush_q;
    if (in_q4) begin
      flush_d = next_flush;
      ir_d    = next_flush ? NOP_WORD : bus.instr_in;
    end
  end

  // Phase counter, instruction register and flush flag; reset forces a flushed first cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_state_q <= Q1;
      ir_q      <= NOP_WORD;
      flush_q   <= 1'b1;
    end else begin
      q_state_q <= q_state_d;
      ir_q      <= ir_d;
      flush_q   <= flush_d;
    end
  end

  // Decode fields follow IR for the whole cycle; writes and PC/stack actions only fire in Q4
  always_comb begin
    bus.q_state          = q_state_q;
    bus.alu_op           = ctrl.op;
    bus.alu_d            = ctrl.d;
    bus.alu_lit_sel      = ctrl.lit_sel;
    bus.alu_b_in         = ir_q[9:7];
    bus.rf_addr          = ir_q[6:0];
    bus.pc_load_val      = PC_WIDTH'(ir_q[10:0]);
    bus.alu_d_wr_en      = in_q4 & active & ctrl.d_wr_en;
    bus.alu_status_wr_en = in_q4 & active & ctrl.status_wr_en;
    bus.pc_inc_en        = in_q4 & ~branch_taken;
    bus.pc_load_en       = in_q4 & active & ctrl.pc_load;
    bus.stack_push       = in_q4 & active & ctrl.stack_push;
    bus.stack_pop        = in_q4 & active & ctrl.stack_pop;
    bus.gie_set          = in_q4 & active & ctrl.gie_set;
  end

endmodule

// File: tb/tb_pic_control_unit.sv
// Directed, table-driven bench for the PIC16 instruction-cycle controller.
// Each table row is one instruction cycle: the word that executes in it,
// the ALU skip inputs, and the expected decode and Q4 pulses.
module tb_pic_control_unit;
  import pic_control_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;

  pic_control_unit_if #(.PC_WIDTH(11)) bus ();

  pic_control_unit #(
    .PC_WIDTH (11),
    .NOP_WORD (14'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [13:0] instr;
    logic        bit_res;
    logic        z;
    logic        flushed;
    logic [3:0]  op;
    logic        d;
    logic        lit;
    logic [6:0]  q4;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mkVec(input string name, input logic [13:0] instr,
                                 input logic bit_res, input logic z, input logic flushed,
                                 input logic [3:0] op, input logic d, input logic lit,
                                 input logic [6:0] q4);
    vec_t v;
    v.name = name; v.instr = instr; v.bit_res = bit_res; v.z = z; v.flushed = flushed;
    v.op = op; v.d = d; v.lit = lit; v.q4 = q4;
    return v;
  endfunction

  // {d_wr_en, status_wr_en, pc_inc_en, pc_load_en, stack_push, stack_pop, gie_set}
  function automatic logic [6:0] pulses();
    return {bus.alu_d_wr_en, bus.alu_status_wr_en, bus.pc_inc_en, bus.pc_load_en,
            bus.stack_push, bus.stack_pop, bus.gie_set};
  endfunction

  task automatic applyStimulus(input logic [13:0] instr, input logic bit_res, input logic z);
    bus.instr_in         = instr;
    bus.alu_bit_test_res = bit_res;
    bus.alu_out_z        = z;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one instruction cycle starting at the Q1 falling edge and ends at the next Q1
  task automatic runCycle(input vec_t v, input logic [13:0] next_instr);
    applyStimulus(next_instr, v.bit_res, v.z);
    checkOutput($sformatf("%s q1 phase", v.name), 16'(bus.q_state), 16'd0);
    checkOutput($sformatf("%s q1 pulses", v.name), 16'(pulses()), 16'd0);
    checkOutput($sformatf("%s op", v.name), 16'(bus.alu_op), 16'(v.op));
    checkOutput($sformatf("%s d", v.name), 16'(bus.alu_d), 16'(v.d));
    checkOutput($sformatf("%s lit_sel", v.name), 16'(bus.alu_lit_sel), 16'(v.lit));
    if (!v.flushed) begin
      checkOutput($sformatf("%s rf_addr", v.name), 16'(bus.rf_addr), 16'(v.instr[6:0]));
      checkOutput($sformatf("%s b_in", v.name), 16'(bus.alu_b_in), 16'(v.instr[9:7]));
      checkOutput($sformatf("%s pc_load_val", v.name), 16'(bus.pc_load_val), 16'(v.instr[10:0]));
    end
    @(negedge clk);
    checkOutput($sformatf("%s q2 phase", v.name), 16'(bus.q_state), 16'd1);
    @(negedge clk);
    checkOutput($sformatf("%s q3 phase", v.name), 16'(bus.q_state), 16'd2);
    checkOutput($sformatf("%s q3 pulses", v.name), 16'(pulses()), 16'd0);
    @(negedge clk);
    checkOutput($sformatf("%s q4 phase", v.name), 16'(bus.q_state), 16'd3);
    checkOutput($sformatf("%s q4 op", v.name), 16'(bus.alu_op), 16'(v.op));
    checkOutput($sformatf("%s q4 pulses", v.name), 16'(pulses()), 16'(v.q4));
    @(negedge clk);
  endtask

  initial begin
    logic [13:0] nxt;
    rst = 1'b1;
    applyStimulus(14'h0000, 1'b0, 1'b0);

    //                name              instr     bit   z     flush op             d     lit   {dwr,swr,inc,ld,push,pop,gie}
    vecs.push_back(mkVec("reset_flush",   14'h0000, 1'b0, 1'b0, 1'b1, alu_op_zero,   1'b0, 1'b0, 7'b0010000));
    vecs.push_back(mkVec("addwf",         14'h07A0, 1'b0, 1'b0, 1'b0, alu_op_add,    1'b1, 1'b0, 7'b1110000));
    vecs.push_back(mkVec("goto",          14'h2923, 1'b0, 1'b0, 1'b0, alu_op_zero,   1'b0, 1'b0, 7'b0001000));
    vecs.push_back(mkVec("goto_shadow",   14'h305A, 1'b0, 1'b0, 1'b1, alu_op_zero,   1'b0, 1'b0, 7'b0010000));
    vecs.push_back(mkVec("btfsc_skip",    14'h1903, 1'b1, 1'b0, 1'b0, alu_op_bc,     1'b0, 1'b0, 7'b0010000));
    vecs.push_back(mkVec("btfsc_shadow",  14'h305A, 1'b0, 1'b0, 1'b1, alu_op_zero,   1'b0, 1'b0, 7'b0010000));
    vecs.push_back(mkVec("btfsc_noskip",  14'h1903, 1'b0, 1'b0, 1'b0, alu_op_bc,     1'b0, 1'b0, 7'b0010000));
    vecs.push_back(mkVec("movlw",         14'h305A, 1'b0, 1'b0, 1'b0, alu_op_passlf, 1'b0, 1'b1, 7'b1010000));
    vecs.push_back(mkVec("decfsz_skip",   14'h0BB0, 1'b0, 1'b1, 1'b0, alu_op_dec,    1'b1, 1'b0, 7'b1010000));
    vecs.push_back(mkVec("decfsz_shadow", 14'h2923, 1'b0, 1'b0, 1'b1, alu_op_zero,   1'b0, 1'b0, 7'b0010000));
    vecs.push_back(mkVec("decfsz_noskip", 14'h0BB0, 1'b0, 1'b0, 1'b0, alu_op_dec,    1'b1, 1'b0, 7'b1010000));
    vecs.push_back(mkVec("call",          14'h2010, 1'b0, 1'b0, 1'b0, alu_op_zero,   1'b0, 1'b0, 7'b0001100));
    vecs.push_back(mkVec("call_shadow",   14'h0BB0, 1'b1, 1'b1, 1'b1, alu_op_zero,   1'b0, 1'b0, 7'b0010000));
    vecs.push_back(mkVec("retlw",         14'h3442, 1'b0, 1'b0, 1'b0, alu_op_passlf, 1'b0, 1'b1, 7'b1000010));
    vecs.push_back(mkVec("retlw_shadow",  14'h2923, 1'b0, 1'b0, 1'b1, alu_op_zero,   1'b0, 1'b0, 7'b0010000));
    vecs.push_back(mkVec("retfie",        14'h0009, 1'b0, 1'b0, 1'b0, alu_op_zero,   1'b0, 1'b0, 7'b0000011));
    vecs.push_back(mkVec("retfie_shadow", 14'h07A0, 1'b0, 1'b0, 1'b1, alu_op_zero,   1'b0, 1'b0, 7'b0010000));
    vecs.push_back(mkVec("bsf",           14'h1583, 1'b0, 1'b0, 1'b0, alu_op_bs,     1'b1, 1'b0, 7'b1010000));
    vecs.push_back(mkVec("btfss_skip",    14'h1D03, 1'b1, 1'b0, 1'b0, alu_op_bs,     1'b0, 1'b0, 7'b0010000));
    vecs.push_back(mkVec("btfss_shadow",  14'h3E05, 1'b0, 1'b0, 1'b1, alu_op_zero,   1'b0, 1'b0, 7'b0010000));
    vecs.push_back(mkVec("addlw",         14'h3E05, 1'b0, 1'b0, 1'b0, alu_op_add,    1'b0, 1'b1, 7'b1110000));
    vecs.push_back(mkVec("subwf_w",       14'h0221, 1'b0, 1'b0, 1'b0, alu_op_sub,    1'b0, 1'b0, 7'b1110000));
    vecs.push_back(mkVec("swapf",         14'h0EA1, 1'b0, 1'b0, 1'b0, alu_op_swap,   1'b1, 1'b0, 7'b1010000));
    vecs.push_back(mkVec("clrf",          14'h01A5, 1'b0, 1'b0, 1'b0, alu_op_zero,   1'b1, 1'b0, 7'b1110000));
    vecs.push_back(mkVec("clrw",          14'h0103, 1'b0, 1'b0, 1'b0, alu_op_zero,   1'b0, 1'b0, 7'b1110000));
    vecs.push_back(mkVec("return",        14'h0008, 1'b0, 1'b0, 1'b0, alu_op_zero,   1'b0, 1'b0, 7'b0000010));
    vecs.push_back(mkVec("return_shadow", 14'h0000, 1'b0, 1'b0, 1'b1, alu_op_zero,   1'b0, 1'b0, 7'b0010000));
    vecs.push_back(mkVec("sleep",         14'h0063, 1'b0, 1'b0, 1'b0, alu_op_zero,   1'b0, 1'b0, 7'b0010000));
    vecs.push_back(mkVec("undefined",     14'h3B00, 1'b0, 1'b0, 1'b0, alu_op_zero,   1'b0, 1'b0, 7'b0010000));

    repeat (2) @(negedge clk);
    checkOutput("in reset phase", 16'(bus.q_state), 16'd0);
    checkOutput("in reset pulses", 16'(pulses()), 16'd0);
    checkOutput("in reset op", 16'(bus.alu_op), 16'(alu_op_zero));
    checkOutput("in reset rf_addr", 16'(bus.rf_addr), 16'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      nxt = (i + 1 < vecs.size()) ? vecs[i + 1].instr : 14'h0000;
      runCycle(vecs[i], nxt);
    end

    // Reset landing in Q3 of an ADDWF must drop its pending Q4 write
    applyStimulus(14'h07A0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("pre-reset addwf op", 16'(bus.alu_op), 16'(alu_op_add));
    repeat (2) @(negedge clk);
    checkOutput("pre-reset q3 phase", 16'(bus.q_state), 16'd2);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid reset phase", 16'(bus.q_state), 16'd0);
    checkOutput("mid reset op", 16'(bus.alu_op), 16'(alu_op_zero));
    checkOutput("mid reset d", 16'(bus.alu_d), 16'd0);
    checkOutput("mid reset pulses", 16'(pulses()), 16'd0);
    @(negedge clk);
    checkOutput("held reset phase", 16'(bus.q_state), 16'd0);
    rst = 1'b0;
    runCycle(mkVec("post_reset_flush", 14'h0000, 1'b0, 1'b0, 1'b1, alu_op_zero, 1'b0, 1'b0, 7'b0010000), 14'h07A0);
    runCycle(mkVec("post_reset_addwf", 14'h07A0, 1'b0, 1'b0, 1'b0, alu_op_add,  1'b1, 1'b0, 7'b1110000), 14'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pic_control_unit.md
Name: pic_control_unit

Overview:
Sequential instruction-cycle controller for the PIC16F core. It runs the Q1–Q4 phase counter, holds the instruction register and decodes the 14-bit PIC16 opcode into ALU control: op, d, write enables, literal select, bit index and register address. It consumes the ALU's skip indicators (bit-test result and zero) to resolve conditional skips. It drives PC and stack control and flushes the pipeline after branches and taken skips.

Parameters:
PC_WIDTH, 11, width of pc_load_val and of the GOTO/CALL target field.
NOP_WORD, 14'h0000, value loaded into the IR on reset and on flush.

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-high
instr_in  in  14  prefetched instruction word from program memory, stable at Q4
alu_bit_test_res  in  1  ALU bit-test result
alu_out_z  in  1  ALU zero indicator (alu_out == 0), valid even when status writes are disabled
q_state  out  2  current phase: 0=Q1, 1=Q2, 2=Q3, 3=Q4
alu_op  out  4  ALU operation, encoded with the shared alu_op_* constants
alu_d  out  1  destination: 0=W, 1=f
alu_d_wr_en  out  1  result write enable; high only in Q4
alu_status_wr_en  out  1  STATUS flag write enable; high only in Q4
alu_lit_sel  out  1  1 = ALU operand lf is the literal IR[7:0]; 0 = register file
alu_b_in  out  3  bit index IR[9:7]
rf_addr  out  7  register file address IR[6:0]
pc_inc_en  out  1  PC increment pulse in Q4
pc_load_en  out  1  PC load pulse in Q4
pc_load_val  out  PC_WIDTH  PC target; IR[10:0] for GOTO/CALL
stack_push  out  1  Q4 pulse (CALL)
stack_pop  out  1  Q4 pulse (RETURN, RETLW, RETFIE)
gie_set  out  1  Q4 pulse (RETFIE)

Behaviour:
- Reset values: q_state=Q1, IR=NOP_WORD, flush=1. All enables and pulses are 0. alu_op=alu_op_zero, alu_d=0.
- Reset mid-cycle: any pending Q4 write or PC action is abandoned. The first instruction cycle after reset is always a flush.
- Q counter: Q1→Q2→Q3→Q4→Q1, free-running. One instruction cycle is 4 clocks.
- IR is loaded from instr_in on the clock edge that ends Q4. The flush register is updated on the same edge.
- Decode outputs (alu_op, alu_d, alu_lit_sel, alu_b_in, rf_addr, pc_load_val) are combinational from IR and are held for all four phases.
- Write enables and pulses are asserted only during Q4.
- Flushed cycle: decode is forced to NOP, all writes are 0, pc_inc_en=1 in Q4.
- Decode, as {op, d, status_wr, lit_sel}:
  - ADDWF/SUBWF/ANDWF/IORWF/XORWF/COMF/INCF/DECF/MOVF: matching op; d=IR[7]; status_wr=1.
  - RLF/RRF: status_wr=1. SWAPF: status_wr=0.
  - MOVWF: passw, d=1, status_wr=0.
  - CLRF: zero, d=1. CLRW: zero, d=0. Both status_wr=1.
  - DECFSZ/INCFSZ: dec/inc, d=IR[7], status_wr=0.
  - BCF/BSF: bc/bs, d_wr_en=1.
  - BTFSC: bc, d_wr_en=0. BTFSS: bs, d_wr_en=0.
  - ADDLW/SUBLW/ANDLW/IORLW/XORLW: lit_sel=1, d=0, status_wr=1.
  - MOVLW: passlf, lit_sel=1, d=0, status_wr=0.
  - RETLW: as MOVLW, plus stack_pop.
  - GOTO: pc_load. CALL: pc_load + stack_push.
  - RETURN: stack_pop. RETFIE: stack_pop + gie_set.
  - NOP, CLRWDT, SLEEP and undefined encodings: no writes, pc_inc only.
- Skip resolution in Q4:
  - BTFSC and BTFSS skip when alu_bit_test_res=1.
  - DECFSZ and INCFSZ skip when alu_out_z=1. The register write-back still occurs.
  - A taken skip sets flush for the next cycle; pc_inc_en=1.
- Branches: GOTO, CALL, RETURN, RETLW and RETFIE assert pc_inc_en=0 and set flush.
- pc_load_en and pc_inc_en are never both high.
- A branch or skip instruction that is itself flushed has no effect: no chained flush.

Decomposition:
- alu_ops.vh (shared): alu_op_* encodings.
- New shared header pic_ctrl.vh: Q-phase constants, opcode field masks and match values, NOP_WORD.
- Sub-module pic_instr_decoder: purely combinational, IR → control bundle plus is_skip_bit, is_skip_z, is_branch.
- Top level holds the Q counter, IR, flush register and Q4 gating.

Test Plan:
1. Reset asserted in Q3, released → q_state=Q1, IR=0x0000; first cycle flushed, pc_inc_en pulses once in Q4, no write enables.
2. IR=0x07A0 (ADDWF 0x20,1) → alu_op=add, alu_d=1, rf_addr=0x20, lit_sel=0; d_wr_en=1 and status_wr_en=1 only in Q4; pc_inc_en=1.
3. IR=0x2923 (GOTO 0x123) → Q4: pc_load_en=1, pc_load_val=0x123, pc_inc_en=0; next instruction (e.g. 0x305A) flushed with no writes.
4. IR=0x1903 (BTFSC 0x03,2): alu_bit_test_res=1 → next instruction flushed; alu_bit_test_res=0 → next instruction executes; d_wr_en=0 in both cases.
5. IR=0x0BB0 (DECFSZ 0x30,1): alu_out_z=1 → d_wr_en=1, status_wr_en=0, next cycle flushed; alu_out_z=0 → no flush.
6. IR=0x2010 (CALL 0x010) followed by IR=0x3442 (RETLW 0x42) → stack_push with pc_load_val=0x010; later stack_pop, alu_op=passlf, lit_sel=1, alu_d=0, d_wr_en=1; each followed by a flushed cycle.
